// File: rtl/shift_pkg.sv
// Shared types and constants for the universal shift register.
// Holds the operation encodings, the operation and controller-state enums, and a
// helper that says which operations may be repeated as a counted burst.
package shift_pkg;

  // Operation encodings as presented on the 3-bit mode input; 6 and 7 are reserved.
  localparam logic [2:0] ModeEncHold = 3'd0;
  localparam logic [2:0] ModeEncShl  = 3'd1;
  localparam logic [2:0] ModeEncShr  = 3'd2;
  localparam logic [2:0] ModeEncLoad = 3'd3;
  localparam logic [2:0] ModeEncRotl = 3'd4;
  localparam logic [2:0] ModeEncRotr = 3'd5;

  typedef enum logic [2:0] {
    ModeHold = ModeEncHold,
    ModeShl  = ModeEncShl,
    ModeShr  = ModeEncShr,
    ModeLoad = ModeEncLoad,
    ModeRotl = ModeEncRotl,
    ModeRotr = ModeEncRotr
  } mode_t;

  typedef enum logic {
    StIdle,
    StBurst
  } state_t;

  // Only shifts and rotates can be repeated; HOLD, LOAD and reserved codes cannot.
  function automatic logic is_burst_mode(input logic [2:0] m);
    return (m == ModeEncShl) || (m == ModeEncShr) ||
           (m == ModeEncRotl) || (m == ModeEncRotr);
  endfunction

endpackage

// File: rtl/shift_op_unit.sv
// Combinational next-value generator for the universal shift register.
// Shared by the direct (single operation) and burst paths.
// Ports:
//   cur       current register value
//   op        operation code (reserved codes behave as HOLD)
//   ser_in_l  serial bit entering at the MSB on SHR
//   ser_in_r  serial bit entering at the LSB on SHL
//   load_data parallel load value
//   nxt       value the register takes if this operation is applied
module shift_op_unit
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [2:0]       op,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = cur;
    case (op)
      ModeEncShl:  nxt = {cur[WIDTH-2:0], ser_in_r};
      ModeEncShr:  nxt = {ser_in_l, cur[WIDTH-1:1]};
      ModeEncLoad: nxt = load_data;
      ModeEncRotl: nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      ModeEncRotr: nxt = {cur[0], cur[WIDTH-1:1]};
      default:     nxt = cur;
    endcase
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, parallel load, logical shift and rotate in both
// directions, plus a counted burst that repeats one shift/rotate N times with a
// registered busy flag and a one-cycle done pulse.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   mode            operation select (0 HOLD,1 SHL,2 SHR,3 LOAD,4 ROTL,5 ROTR)
//   en              enables the direct operation while idle
//   load_data       parallel load value
//   ser_in_l        serial input at the MSB (SHR)
//   ser_in_r        serial input at the LSB (SHL)
//   start           request a burst of shift_cnt operations of the current mode
//   shift_cnt       burst length N
//   q               register contents
//   ser_out_l       q MSB
//   ser_out_r       q LSB
//   busy            burst in progress
//   done            one-cycle pulse after the final burst operation
module shift_reg_univ
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic             en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_cnt,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [2:0]       op_sel;
  logic [WIDTH-1:0] op_next;

  // During a burst the captured mode drives the datapath; the live mode is ignored.
  assign op_sel = (state_q == StBurst) ? mode_q : mode;

  shift_op_unit #(
    .WIDTH (WIDTH)
  ) u_op (
    .cur       (q_q),
    .op        (op_sel),
    .ser_in_l  (ser_in_l),
    .ser_in_r  (ser_in_r),
    .load_data (load_data),
    .nxt       (op_next)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    q_d     = q_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start && is_burst_mode(mode)) begin
          mode_d = mode_t'(mode);
          if (shift_cnt == '0) begin
            // Empty burst: no operation, but still acknowledge with done.
            done_d = 1'b1;
          end else begin
            q_d   = op_next;
            rem_d = shift_cnt - CNT_W'(1);
            if (shift_cnt == CNT_W'(1)) begin
              done_d = 1'b1;
            end else begin
              state_d = StBurst;
              busy_d  = 1'b1;
            end
          end
        end else if (en) begin
          q_d = op_next;
        end
      end
      StBurst: begin
        q_d   = op_next;
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mode_q  <= ModeHold;
      rem_q   <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q         = q_q;
  assign ser_out_l = q_q[WIDTH-1];
  assign ser_out_r = q_q[0];
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ (WIDTH=8, CNT_W=4).
// A behavioural reference model predicts every cycle; predictions are queued when
// stimulus is applied and compared once the DUT has clocked.
module tb_shift_reg_univ;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] mode;
  logic       en;
  logic [7:0] load_data;
  logic       ser_in_l;
  logic       ser_in_r;
  logic       start;
  logic [3:0] shift_cnt;
  logic [7:0] q;
  logic       ser_out_l;
  logic       ser_out_r;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [7:0] m_q;
  logic       m_busy;
  logic       m_done;
  int         m_left;
  logic [2:0] m_mode;

  logic [11:0] exp_fifo[$];

  always #5 clk = ~clk;

  shift_reg_univ #(
    .WIDTH (8),
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .en        (en),
    .load_data (load_data),
    .ser_in_l  (ser_in_l),
    .ser_in_r  (ser_in_r),
    .start     (start),
    .shift_cnt (shift_cnt),
    .q         (q),
    .ser_out_l (ser_out_l),
    .ser_out_r (ser_out_r),
    .busy      (busy),
    .done      (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] apply_op(input logic [7:0] v, input logic [2:0] m,
                                          input logic sl, input logic sr,
                                          input logic [7:0] ld);
    case (m)
      3'd1:    return {v[6:0], sr};
      3'd2:    return {sl, v[7:1]};
      3'd3:    return ld;
      3'd4:    return {v[6:0], v[7]};
      3'd5:    return {v[0], v[7:1]};
      default: return v;
    endcase
  endfunction

  function automatic logic burst_ok(input logic [2:0] m);
    return m == 3'd1 || m == 3'd2 || m == 3'd4 || m == 3'd5;
  endfunction

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_edge();
    if (reset) begin
      m_q = 8'h00; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    end else if (m_left > 0) begin
      m_q    = apply_op(m_q, m_mode, ser_in_l, ser_in_r, load_data);
      m_left = m_left - 1;
      m_busy = (m_left != 0);
      m_done = (m_left == 0);
    end else begin
      m_busy = 1'b0;
      m_done = 1'b0;
      if (start && burst_ok(mode)) begin
        m_mode = mode;
        if (shift_cnt == 4'd0) begin
          m_done = 1'b1;
        end else begin
          m_q    = apply_op(m_q, mode, ser_in_l, ser_in_r, load_data);
          m_left = int'(shift_cnt) - 1;
          m_busy = (m_left != 0);
          m_done = (m_left == 0);
        end
      end else if (en) begin
        m_q = apply_op(m_q, mode, ser_in_l, ser_in_r, load_data);
      end
    end
  endtask

  // One clock: predict, queue, clock the DUT, then pop and compare.
  task automatic step(input string tag);
    logic [11:0] e;
    model_edge();
    exp_fifo.push_back({m_q, m_q[7], m_q[0], m_busy, m_done});
    @(posedge clk);
    #1;
    e = exp_fifo.pop_front();
    check_eq(tag, {20'd0, q, ser_out_l, ser_out_r, busy, done}, {20'd0, e});
  endtask

  task automatic drive(input logic [2:0] m, input logic e, input logic s, input logic [3:0] n);
    mode = m; en = e; start = s; shift_cnt = n;
  endtask

  initial begin
    reset = 1'b1; mode = 3'd0; en = 1'b0; load_data = 8'h00;
    ser_in_l = 1'b0; ser_in_r = 1'b0; start = 1'b0; shift_cnt = 4'd0;
    m_q = 8'h00; m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_mode = 3'd0;
    #2;
    step("init_reset");
    reset = 1'b0;

    // 1: random activity, then reset held two cycles.
    for (int i = 0; i < 12; i++) begin
      mode = 3'($urandom_range(0, 7)); en = 1'($urandom); start = ($urandom_range(0, 3) == 0);
      shift_cnt = 4'($urandom); load_data = 8'($urandom);
      ser_in_l = 1'($urandom); ser_in_r = 1'($urandom);
      step("rand_pre");
    end
    reset = 1'b1; start = 1'b0;
    step("rst1");
    step("rst2");
    check_eq("rst_state", {q, busy, done}, {8'h00, 1'b0, 1'b0});
    reset = 1'b0;

    // 2: load, rotate left/right, hold with en low.
    load_data = 8'hA5; ser_in_l = 1'b0; ser_in_r = 1'b0;
    drive(3'd3, 1'b1, 1'b0, 4'd0); step("ld_a5");
    check_eq("ld_a5_q", q, 8'hA5);
    drive(3'd4, 1'b1, 1'b0, 4'd0); step("rotl");
    check_eq("rotl_q", q, 8'h4B);
    drive(3'd5, 1'b1, 1'b0, 4'd0); step("rotr");
    check_eq("rotr_q", q, 8'hA5);
    drive(3'd1, 1'b0, 1'b0, 4'd0); step("en_low");
    check_eq("hold_q", q, 8'hA5);

    // 3: serial in/out at the boundaries.
    load_data = 8'h80;
    drive(3'd3, 1'b1, 1'b0, 4'd0); step("ld_80");
    check_eq("ser_out_l_pre", ser_out_l, 1'b1);
    ser_in_r = 1'b1;
    drive(3'd1, 1'b1, 1'b0, 4'd0); step("shl");
    check_eq("shl_q", q, 8'h01);
    ser_in_r = 1'b0; ser_in_l = 1'b1;
    drive(3'd2, 1'b1, 1'b0, 4'd0); step("shr");
    check_eq("shr_q", q, 8'h80);
    ser_in_l = 1'b0;

    // 4: ROTL burst of 3 with interfering inputs mid-burst.
    load_data = 8'h01;
    drive(3'd3, 1'b1, 1'b0, 4'd0); step("ld_01");
    drive(3'd4, 1'b1, 1'b1, 4'd3); step("b_e0");
    check_eq("b_e0_q", {q, busy, done}, {8'h02, 1'b1, 1'b0});
    load_data = 8'hFF;
    drive(3'd3, 1'b1, 1'b1, 4'd9); step("b_e1");
    check_eq("b_e1_q", {q, busy, done}, {8'h04, 1'b1, 1'b0});
    drive(3'd2, 1'b0, 1'b1, 4'd7); step("b_e2");
    check_eq("b_e2_q", {q, busy, done}, {8'h08, 1'b0, 1'b1});
    drive(3'd0, 1'b0, 1'b0, 4'd0); step("b_after");
    check_eq("b_after_q", {q, busy, done}, {8'h08, 1'b0, 1'b0});

    // 5: empty burst, and start with LOAD acting as a direct load.
    drive(3'd4, 1'b1, 1'b1, 4'd0); step("n0");
    check_eq("n0_q", {q, busy, done}, {8'h08, 1'b0, 1'b1});
    load_data = 8'h3C;
    drive(3'd3, 1'b1, 1'b1, 4'd4); step("st_load");
    check_eq("st_load_q", {q, busy, done}, {8'h3C, 1'b0, 1'b0});

    // 6: SHR burst of 5 from F0 aborted by reset after two operations.
    load_data = 8'hF0;
    drive(3'd3, 1'b1, 1'b0, 4'd0); step("ld_f0");
    drive(3'd2, 1'b1, 1'b1, 4'd5); step("ab_e0");
    drive(3'd0, 1'b0, 1'b0, 4'd0); step("ab_e1");
    check_eq("ab_e1_q", {q, busy}, {8'h3C, 1'b1});
    reset = 1'b1; step("ab_rst");
    check_eq("ab_rst_q", {q, busy, done}, {8'h00, 1'b0, 1'b0});
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step("ab_idle");
      check_eq("ab_no_done", done, 1'b0);
    end

    // Back-to-back: done and a new start coincide; long bursts (N > WIDTH).
    load_data = 8'h96;
    drive(3'd3, 1'b1, 1'b0, 4'd0); step("ld_96");
    drive(3'd5, 1'b1, 1'b1, 4'd2); step("bb_e0");
    drive(3'd5, 1'b1, 1'b0, 4'd0); step("bb_e1");
    drive(3'd1, 1'b1, 1'b1, 4'd15); ser_in_r = 1'b1; step("bb_new");
    drive(3'd0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 15; i++) step("long_shl");
    check_eq("long_shl_q", q, 8'hFF);

    // Randomised traffic checked by the model.
    for (int i = 0; i < 150; i++) begin
      mode = 3'($urandom_range(0, 7)); en = 1'($urandom); start = ($urandom_range(0, 2) == 0);
      shift_cnt = 4'($urandom); load_data = 8'($urandom);
      ser_in_l = 1'($urandom); ser_in_r = 1'($urandom);
      reset = ($urandom_range(0, 40) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register, the next generation of the team's single-bit D flip-flop. It provides a WIDTH-bit register with hold, parallel load, logical shift and rotate in both directions, plus a counted burst mode that repeats a shift or rotate N times under a busy/done handshake. It is a general storage and serialisation primitive for datapaths and serial links in the design.

## Interface
- WIDTH, 8: register width in bits, must be ≥ 2.
- CNT_W, 4: width of the burst count; bursts of up to 2^CNT_W−1 operations.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mode  in  3  operation select: 0 HOLD, 1 SHL, 2 SHR, 3 LOAD, 4 ROTL, 5 ROTR, 6/7 reserved (treated as HOLD).
- en  in  1  enables the direct operation while IDLE; when low the register holds.
- load_data  in  WIDTH  parallel load value.
- ser_in_l  in  1  serial input entering at the MSB on SHR.
- ser_in_r  in  1  serial input entering at the LSB on SHL.
- start  in  1  requests a burst of shift_cnt operations of the current mode.
- shift_cnt  in  CNT_W  burst length N.
- q  out  WIDTH  register contents.
- ser_out_l  out  1  always q[WIDTH−1].
- ser_out_r  out  1  always q[0].
- busy  out  1  a burst is in progress; registered.
- done  out  1  one-cycle pulse after the final burst operation; registered.

## Operation
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Operations, where q is the current value:
  - SHL: q ← {q[W−2:0], ser_in_r}.
  - SHR: q ← {ser_in_l, q[W−1:1]}.
  - ROTL: q ← {q[W−2:0], q[W−1]}.
  - ROTR: q ← {q[0], q[W−1:1]}.
  - LOAD: q ← load_data.
- States:
  - IDLE:
    - start=1 with a burst-capable mode (1, 2, 4, 5): capture the mode, perform the first operation on this edge, and set rem ← N−1.
      - N=0: no operation; done=1 next cycle; stay in IDLE.
      - N=1: one operation; done=1; stay in IDLE.
      - N≥2: go to BURST; busy=1.
    - start=1 with mode HOLD, LOAD or reserved: start is ignored and the direct path applies.
    - start=0: if en=1, apply mode once; else hold.
  - BURST:
    - Apply the captured mode every edge. mode, en, load_data and start are ignored.
    - ser_in_l and ser_in_r are sampled live each cycle.
    - rem decrements each edge.
    - On the edge where rem=1: final operation, go to IDLE, busy←0, done←1.
- Boundary conditions:
  - N > WIDTH is legal. A shift fills the register from the serial input; a rotate wraps.
  - start asserted during BURST is ignored; no queueing.
  - reset at any time: q=0, busy=0, done=0, rem=0, state IDLE. An aborted burst produces no done.

## Timing
- Reset values: q=0, busy=0, done=0, ser_out_l=0, ser_out_r=0.
- Direct operation: result appears on q one edge after sampling (latency 1).
- Burst with start sampled at edge E0 and N≥1:
  - Operations occur at E0 … E0+N−1.
  - busy is high from after E0 until after E0+N−1 (N≥2 only).
  - done is high for exactly the cycle after E0+N−1.
- done and start may coincide; a new burst is accepted in the same cycle done is high.
- ser_out_l and ser_out_r are combinational from q; no extra latency.

## Structure
- Package shift_pkg holds:
  - mode_t enum: HOLD, SHL, SHR, LOAD, ROTL, ROTR.
  - state_t enum: IDLE, BURST.
  - Mode encodings as localparams.
- Sub-module shift_op_unit: purely combinational; computes the next q from q, the operation, ser_in_l, ser_in_r and load_data. It is shared by the direct and burst paths.
- The top level holds the state register, the rem counter, the busy/done flags and q.

## Test plan
All scenarios use WIDTH=8, CNT_W=4.
1. Reset held 2 cycles after random activity → q=8'h00, busy=0, done=0.
2. LOAD 8'hA5 (en=1), then ROTL → q=8'h4B; then ROTR → q=8'hA5; then en=0 with mode SHL → q holds 8'hA5.
3. q=8'h80, SHL with ser_in_r=1 → ser_out_l=1 before the edge, q=8'h01 after; SHR with ser_in_l=1 → q=8'h80.
4. q=8'h01, start with ROTL and N=3 → q=8'h02, 8'h04, 8'h08 on consecutive edges; busy high 2 cycles; done pulses once; start and mode changes mid-burst have no effect.
5. start with N=0 → q unchanged, done=1 for one cycle, busy stays 0; start with LOAD → behaves as a direct load, no done.
6. Burst SHR N=5 from 8'hF0, reset asserted after the 2nd operation → q=8'h00, busy=0, done never asserts.
